mmu_host_seq: RTL and testbench

Host-side sequencer for the matrix multiply unit. It accepts A and B matrix rows from a valid/ready stream and writes them into the user ports of the matrix BRAM, then pulses `start` to the DMA controller. It waits for completion under a timeout, and streams the N result rows of C back out with backpressure. It replaces hand-driven testbench loading. It also adds B-matrix reuse across runs, which the earlier flow cannot do.

---
 rtl/mmu_host_seq_pkg.sv | 24 ++
 rtl/mmu_host_seq_row_skid_buf.sv | 53 +++++
 rtl/mmu_host_seq.sv | 170 +++++++++++++++++
 tb/tb_mmu_host_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_host_seq_pkg.sv
// mmu_host_seq_pkg: shared sizes, state encoding and helpers
// for the matrix-multiply host sequencer.
package mmu_host_seq_pkg;

  localparam int MAT_SIZE   = 6;
  localparam int DATA_WIDTH = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } st_e;

endpackage

// File: rtl/mmu_host_seq_row_skid_buf.sv
// row_skid_buf: 2-deep row FIFO with valid/ready output side and an
// occupancy count used upstream to gate memory reads.
module row_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         pop;

  assign out_valid = count != 2'd0;
  assign out_data  = head;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      unique case (1'b1)
        push && pop: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        pop && !push: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        push && !pop: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mmu_host_seq.sv
// mmu_host_seq: loads A/B rows into the matrix BRAM, kicks the DMA,
// waits for completion under a timeout and streams C rows back out.
module mmu_host_seq
  import mmu_host_seq_pkg::*;
#(
  parameter int N            = MAT_SIZE,
  parameter int WIDTH        = DATA_WIDTH,
  parameter int ADDR         = clog2(N),
  parameter int START_CYCLES = 3,
  parameter int TIMEOUT      = 4096,
  parameter int TW           = clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              keep_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [N*WIDTH-1:0] in_data,
  output logic              A_USR_wr,
  output logic [ADDR-1:0]   A_USR_addr,
  output logic [N*WIDTH-1:0] A_USR_din,
  output logic              B_USR_wr,
  output logic [ADDR-1:0]   B_USR_addr,
  output logic [N*WIDTH-1:0] B_USR_din,
  output logic              C_USR_rd,
  output logic [ADDR-1:0]   C_USR_addr,
  input  logic [N*WIDTH-1:0] C_USR_dout,
  output logic              start,
  input  logic              mat_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int RW  = N * WIDTH;
  localparam int SW  = clog2(START_CYCLES + 1);
  localparam int NM1 = N - 1;
  localparam int SM1 = START_CYCLES - 1;
  localparam int TM1 = TIMEOUT - 1;

  localparam logic [ADDR:0] N_C    = N[ADDR:0];
  localparam logic [ADDR:0] N_L    = NM1[ADDR:0];
  localparam logic [SW-1:0] S_LAST = SM1[SW-1:0];
  localparam logic [TW-1:0] T_LAST = TM1[TW-1:0];

  st_e           state;
  logic [ADDR:0] a_cnt, b_cnt;
  logic [ADDR:0] a_nx, b_nx;
  logic [ADDR:0] rcnt, ocnt;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic          acc, a_acc, b_acc;
  logic          pend, pop;
  logic [1:0]    occ;

  assign in_ready = (state == ST_LOAD) &
                    (in_sel ? (b_cnt < N_C) : (a_cnt < N_C));
  assign acc   = in_valid & in_ready;
  assign a_acc = acc & ~in_sel;
  assign b_acc = acc & in_sel;
  assign a_nx  = a_acc ? a_cnt + 1'b1 : a_cnt;
  assign b_nx  = b_acc ? b_cnt + 1'b1 : b_cnt;

  assign busy     = state != ST_IDLE;
  assign pop      = out_valid & out_ready;
  assign out_last = out_valid & (ocnt == N_L);

  // Rows leaving the buffer this cycle free their slot for a new read,
  // which keeps one row per cycle flowing with out_ready held high.
  assign C_USR_rd = (state == ST_DRAIN) & (rcnt < N_C) &
                    (({1'b0, occ} + {2'b0, pend}) <
                     (3'd2 + {2'b0, pop}));
  assign C_USR_addr = C_USR_rd ? rcnt[ADDR-1:0] : '0;

  row_skid_buf #(
    .W(RW)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pend),
    .din      (C_USR_dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (occ)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_cnt      <= '0;
      b_cnt      <= '0;
      rcnt       <= '0;
      ocnt       <= '0;
      scnt       <= '0;
      tcnt       <= '0;
      pend       <= 1'b0;
      A_USR_wr   <= 1'b0;
      A_USR_addr <= '0;
      A_USR_din  <= '0;
      B_USR_wr   <= 1'b0;
      B_USR_addr <= '0;
      B_USR_din  <= '0;
      start      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      A_USR_wr <= 1'b0;
      B_USR_wr <= 1'b0;
      done     <= 1'b0;
      pend     <= C_USR_rd;
      if (C_USR_rd) rcnt <= rcnt + 1'b1;
      if (pop)      ocnt <= ocnt + 1'b1;
      if (a_acc) begin
        A_USR_wr   <= 1'b1;
        A_USR_addr <= a_cnt[ADDR-1:0];
        A_USR_din  <= in_data;
        a_cnt      <= a_nx;
      end
      if (b_acc) begin
        B_USR_wr   <= 1'b1;
        B_USR_addr <= b_cnt[ADDR-1:0];
        B_USR_din  <= in_data;
        b_cnt      <= b_nx;
      end
      unique case (state)
        ST_IDLE: if (go) begin
          state <= ST_LOAD;
          err   <= 1'b0;
          a_cnt <= '0;
          b_cnt <= keep_b ? N_C : '0;
          rcnt  <= '0;
          ocnt  <= '0;
        end
        ST_LOAD: if (a_nx == N_C && b_nx == N_C) begin
          state <= ST_START;
          start <= 1'b1;
          scnt  <= '0;
        end
        ST_START: if (scnt == S_LAST) begin
          state <= ST_WAIT;
          start <= 1'b0;
          tcnt  <= '0;
        end else begin
          scnt <= scnt + 1'b1;
        end
        ST_WAIT: if (mat_done) begin
          state <= ST_DRAIN;
        end else if (tcnt == T_LAST) begin
          state <= ST_IDLE;
          err   <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        ST_DRAIN: if (pop && ocnt == N_L) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_host_seq.sv
// tb_mmu_host_seq: randomized run-level bench for mmu_host_seq with
// queue/array models of the A, B and C matrix memories.
`timescale 1ns/1ps
module tb_mmu_host_seq;

  localparam int N  = 6;
  localparam int W  = 16;
  localparam int RW = N * W;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          keep_b = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sel = 1'b0;
  logic [RW-1:0] in_data = '0;
  logic          mat_done = 1'b0;
  logic          out_ready = 1'b0;
  logic [RW-1:0] c_dout = '0;

  logic          in_ready;
  logic          A_USR_wr, B_USR_wr, C_USR_rd;
  logic [AW-1:0] A_USR_addr, B_USR_addr, C_USR_addr;
  logic [RW-1:0] A_USR_din, B_USR_din, out_data;
  logic          start, out_valid, out_last, busy, done, err;

  mmu_host_seq #(
    .N(N), .WIDTH(W), .START_CYCLES(3), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .keep_b(keep_b),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data),
    .A_USR_wr(A_USR_wr), .A_USR_addr(A_USR_addr),
    .A_USR_din(A_USR_din),
    .B_USR_wr(B_USR_wr), .B_USR_addr(B_USR_addr),
    .B_USR_din(B_USR_din),
    .C_USR_rd(C_USR_rd), .C_USR_addr(C_USR_addr),
    .C_USR_dout(c_dout),
    .start(start), .mat_done(mat_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [RW-1:0] mem_c [8];
  logic [AW-1:0] wa_addr [$];
  logic [AW-1:0] wb_addr [$];
  logic [RW-1:0] wa_data [$];
  logic [RW-1:0] wb_data [$];
  int            start_cyc = 0;
  int            done_cnt = 0;
  int            checks = 0;
  int            errors = 0;

  always @(posedge clk)
    if (C_USR_rd) c_dout <= mem_c[C_USR_addr];

  always @(negedge clk) begin
    if (A_USR_wr) begin
      wa_addr.push_back(A_USR_addr);
      wa_data.push_back(A_USR_din);
    end
    if (B_USR_wr) begin
      wb_addr.push_back(B_USR_addr);
      wb_data.push_back(B_USR_din);
    end
    if (start) start_cyc <= start_cyc + 1;
    if (done)  done_cnt  <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {in_ready, A_USR_wr, A_USR_addr, B_USR_wr,
        B_USR_addr, C_USR_rd, C_USR_addr, start, out_valid,
        out_last, busy, done, err}, '0);
    chk({tag, "_adin"}, A_USR_din, '0);
    chk({tag, "_bdin"}, B_USR_din, '0);
    chk({tag, "_odat"}, out_data, '0);
  endtask

  function automatic logic [RW-1:0] rnd();
    return {$urandom, $urandom, $urandom};
  endfunction

  // mode 0: A,B interleave; 1: all A then refused A probe, then B;
  // 2: random order/valid plus stray mat_done and go pulses.
  task automatic run(input bit kb, input int mode, input bit stall,
                     input bit tmo, input bit rstm);
    logic [RW-1:0] ra [N];
    logic [RW-1:0] rb [N];
    logic [RW-1:0] pd;
    logic [AW-1:0] ai;
    int  ia, ib, g, a0, b0, s0, d0, n, got, cyc, fh, lh, dly;
    bit  probed, pb, sel, v, pv, pr, pl;
    for (int i = 0; i < N; i++) begin
      ra[i] = (mode == 0 && !kb) ? {N{16'h0001}} : rnd();
      rb[i] = rnd();
      mem_c[i] = rnd();
    end
    a0 = wa_addr.size();
    b0 = wb_addr.size();
    s0 = start_cyc;
    d0 = done_cnt;
    @(negedge clk); go = 1'b1; keep_b = kb;
    @(negedge clk); go = 1'b0; keep_b = 1'b0;
    #1;
    chk("busy_rise", busy, 1);
    chk("err_clear", err, 0);
    ia = 0;
    ib = kb ? N : 0;
    g = 0;
    probed = !(mode == 1 || kb);
    while ((ia < N || ib < N || !probed) && g < 300) begin
      @(negedge clk);
      g++;
      mat_done = (mode == 2 && g == 1);
      v = 1'b1;
      pb = !probed && (kb || ia == N);
      if (pb)             sel = kb;
      else if (mode == 1) sel = ia == N;
      else if (mode == 2) begin
        v = $urandom_range(0, 3) != 0;
        if (ia == N)      sel = 1'b1;
        else if (ib == N) sel = 1'b0;
        else              sel = $urandom_range(0, 1) == 1;
      end else
        sel = !(ia < N && (ib >= N || ia <= ib));
      in_valid = v;
      in_sel = sel;
      if (!sel) in_data = ia < N ? ra[ia] : rnd();
      else      in_data = ib < N ? rb[ib] : rnd();
      #1;
      if (pb) begin
        chk(kb ? "b_refused" : "a_full", in_ready, 0);
        probed = 1'b1;
      end else if (v && in_ready) begin
        if (sel) ib++;
        else     ia++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    mat_done = 1'b0;
    #1;
    chk("start_rise", start, 1);
    n = 0;
    while (start && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("start_len", start_cyc - s0, 3);
    chk("a_wr_n", wa_addr.size() - a0, N);
    chk("b_wr_n", wb_addr.size() - b0, kb ? 0 : N);
    for (int i = 0; i < N; i++) begin
      ai = i[AW-1:0];
      if (a0 + i < wa_addr.size())
        chk("a_wr", {wa_addr[a0+i], wa_data[a0+i]}, {ai, ra[i]});
      if (!kb && b0 + i < wb_addr.size())
        chk("b_wr", {wb_addr[b0+i], wb_data[b0+i]}, {ai, rb[i]});
    end
    if (tmo) begin
      n = 0;
      while (!err && n < 40) begin
        @(negedge clk); #1; n++;
      end
      chk("tmo_cycles", n, 16);
      chk("tmo_idle", busy, 0);
      chk("tmo_no_done", done_cnt - d0, 0);
      return;
    end
    dly = $urandom_range(0, 6);
    repeat (dly) @(negedge clk);
    @(negedge clk);
    go = (mode == 2);
    mat_done = 1'b1;
    @(negedge clk);
    go = 1'b0;
    mat_done = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rd_first", {C_USR_rd, C_USR_addr}, {1'b1, 3'd0});
    @(negedge clk); #1;
    chk("ov_early", out_valid, 0);
    got = 0; cyc = 0; fh = 0; lh = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    while (got < N && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (rstm && got == 2) begin
        rst_n = 1'b0;
        @(negedge clk); #1;
        check_zero("rst_mid");
        rst_n = 1'b1;
        out_ready = 1'b0;
        return;
      end
      if (stall)          out_ready = !(cyc >= 2 && cyc < 12);
      else if (mode == 2) out_ready = $urandom_range(0, 1) == 1;
      else                out_ready = 1'b1;
      #1;
      if (cyc == 1) chk("ov_row0", out_valid, 1);
      if (pv && !pr)
        chk("hold", {out_valid, out_last, out_data}, {1'b1, pl, pd});
      if (out_valid && out_ready) begin
        chk("row", out_data, mem_c[got]);
        chk("last", out_last, got == N - 1);
        if (got == 0) fh = cyc;
        lh = cyc;
        got++;
      end
      pv = out_valid; pr = out_ready; pl = out_last; pd = out_data;
    end
    chk("rows_n", got, N);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("done_pulse", {done, busy}, 2'b10);
    repeat (3) @(negedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    if (mode == 0 && !stall) chk("thruput", lh - fh, N - 1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    run(1'b0, 0, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1, 1'b1, 1'b0, 1'b0);
    run(1'b1, 0, 1'b0, 1'b0, 1'b0);
    run(1'b0, 0, 1'b0, 1'b1, 1'b0);
    run(1'b0, 2, 1'b0, 1'b0, 1'b0);
    run(1'b0, 0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) run(k[0], 2, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
